ram_port_arbiter: RTL and testbench

//  Shares the single-ported word RAM between the instruction-fetch port (read-only) and the data port (load/store).

---
 rtl/ram_port_arbiter_pkg.sv | 17 +
 rtl/ram_lane_align.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 101 ++++++++++
 tb/tb_ram_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: address/word types and access sizes.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORDS  = 2 ** (ADDR_W - 2);

  typedef logic [ADDR_W-1:0] RamAddress;
  typedef logic [31:0]       Word;

  // 2'b11 is reserved and always reported as an error.
  typedef enum logic [1:0] {
    ACCESS_BYTE = 2'd0,
    ACCESS_HALF = 2'd1,
    ACCESS_WORD = 2'd2
  } AccessSize;

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane handling for one RAM word: load extract/extend, store merge, misalignment check.
module ram_lane_align
  import ram_port_arbiter_pkg::*;
(
  input  AccessSize  size,
  input  logic       zero_ext,
  input  logic [1:0] lane,
  input  Word        ram_word,
  input  Word        wdata,
  output logic       misalign,
  output Word        load_data,
  output Word        merged
);

  logic [3:0] mask;
  Word        shifted;
  Word        raw;

  always_comb begin
    shifted   = wdata << {lane, 3'b000};
    raw       = ram_word >> {lane, 3'b000};
    misalign  = 1'b0;
    mask      = '0;
    load_data = '0;
    case (size)
      ACCESS_BYTE: begin
        mask      = 4'b0001 << lane;
        load_data = zero_ext ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      end
      ACCESS_HALF: begin
        misalign  = lane[0];
        mask      = 4'b0011 << lane;
        load_data = zero_ext ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      end
      ACCESS_WORD: begin
        misalign  = |lane;
        mask      = 4'hF;
        load_data = ram_word;
      end
      default: misalign = 1'b1;
    endcase

    merged = ram_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = shifted[8*k +: 8];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-ported word RAM between instruction fetch and data load/store.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      if_req,
  input  RamAddress if_addr,
  output logic      if_gnt,
  output logic      if_rsp_valid,
  output Word       if_rdata,
  output logic      if_err,
  input  logic      d_req,
  input  logic      d_we,
  input  AccessSize d_size,
  input  logic      d_unsigned,
  input  RamAddress d_addr,
  input  Word       d_wdata,
  output logic      d_gnt,
  output logic      d_rsp_valid,
  output Word       d_rdata,
  output logic      d_err
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  Word           mem [WORDS];

  RamAddress sel_addr;
  AccessSize sel_size;
  logic      sel_zext;
  Word       ram_word;
  Word       load_data;
  Word       merged;
  logic      misalign;
  logic      write_enable;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (d_req && (!if_req || starve_cnt != LIMIT)) d_gnt  = 1'b1;
      else if (if_req)                               if_gnt = 1'b1;
    end
  end

  // Idle cycles present the fetch address; nothing is written then.
  always_comb begin
    sel_addr = d_gnt ? d_addr     : if_addr;
    sel_size = d_gnt ? d_size     : ACCESS_WORD;
    sel_zext = d_gnt ? d_unsigned : 1'b1;
  end

  assign ram_word     = mem[sel_addr[ADDR_W-1:2]];
  assign write_enable = d_gnt && d_we && !misalign;

  ram_lane_align u_align (
    .size      (sel_size),
    .zero_ext  (sel_zext),
    .lane      (sel_addr[1:0]),
    .ram_word  (ram_word),
    .wdata     (d_wdata),
    .misalign  (misalign),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (write_enable) begin
      mem[sel_addr[ADDR_W-1:2]] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt   <= '0;
      if_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      if (!if_req || if_gnt)      starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      if_rsp_valid <= if_gnt;
      if_err       <= if_gnt && misalign;
      if_rdata     <= (if_gnt && !misalign) ? load_data : '0;
      d_rsp_valid  <= d_gnt;
      d_err        <= d_gnt && misalign;
      d_rdata      <= (d_gnt && !d_we && !misalign) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a byte-array memory model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int unsigned LIM = 4;

  logic      clk;
  logic      reset;
  logic      if_req;
  RamAddress if_addr;
  logic      if_gnt;
  logic      if_rsp_valid;
  Word       if_rdata;
  logic      if_err;
  logic      d_req;
  logic      d_we;
  AccessSize d_size;
  logic      d_unsigned;
  RamAddress d_addr;
  Word       d_wdata;
  logic      d_gnt;
  logic      d_rsp_valid;
  Word       d_rdata;
  logic      d_err;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [7:0]  mem_m [256];

  ram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  // Little-endian gather of nb bytes from the model, then extension.
  function automatic logic [31:0] model_load(input int unsigned nb, input logic uns, input logic [7:0] a);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < nb; i++) v |= 32'(mem_m[8'(a + i)]) << (8 * i);
    if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
  endtask

  // Entered and left at posedge+1; the grant lands on the next posedge.
  task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [7:0] a, input logic [31:0] wd, input string tag,
                         output logic [31:0] obs);
    int unsigned waited = 0;
    logic        e;
    logic [31:0] exp_rd;
    d_req = 1'b1; d_we = we; d_size = AccessSize'(sz); d_unsigned = uns; d_addr = a; d_wdata = wd;
    @(negedge clk);
    while (!d_gnt && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_gnt"}, 32'(d_gnt), 32'd1);
    e = model_err(sz, a);
    exp_rd = (e || we) ? 32'd0 : model_load(32'd1 << sz, uns, a);
    if (we && !e)
      for (int unsigned i = 0; i < (32'd1 << sz); i++) mem_m[8'(a + i)] = 8'(wd >> (8 * i));
    @(posedge clk);
    #1;
    d_req = 1'b0;
    obs = d_rdata;
    check({tag, "_valid"}, 32'(d_rsp_valid), 32'd1);
    check({tag, "_rdata"}, d_rdata, exp_rd);
    check({tag, "_err"}, 32'(d_err), 32'(e));
  endtask

  task automatic fetch_op(input logic [7:0] a, input string tag);
    int unsigned waited = 0;
    logic        e;
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    while (!if_gnt && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_gnt"}, 32'(if_gnt), 32'd1);
    e = (a[1:0] != 2'd0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    check({tag, "_valid"}, 32'(if_rsp_valid), 32'd1);
    check({tag, "_rdata"}, if_rdata, e ? 32'd0 : model_load(4, 1'b1, a));
    check({tag, "_err"}, 32'(if_err), 32'(e));
  endtask

  initial begin
    logic [31:0] obs;
    int unsigned losses;
    logic        exp_if;
    logic        prev_d;

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = ACCESS_WORD; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    d_req = 1'b1; if_req = 1'b1;
    #1;
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_d_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_if_valid", 32'(if_rsp_valid), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_errs", {30'd0, d_err, if_err}, 32'd0);
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word store/load
    data_op(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, "t1_st", obs);
    data_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "t1_ld", obs);
    check("t1_const", obs, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads
    data_op(1'b1, 2'd0, 1'b0, 8'h13, 32'h0000007F, "t2_st", obs);
    data_op(1'b0, 2'd0, 1'b0, 8'h12, 32'h0, "t2_lds", obs);
    check("t2_lds_const", obs, 32'hFFFFFFAD);
    data_op(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, "t2_ldu", obs);
    check("t2_ldu_const", obs, 32'h0000007F);
    data_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "t2_word", obs);
    check("t2_word_const", obs, 32'h7FADBEEF);

    // Misaligned store and fetch
    data_op(1'b1, 2'd1, 1'b0, 8'h11, 32'h0000CAFE, "t3_st", obs);
    data_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "t3_ld", obs);
    check("t3_unchanged", obs, 32'h7FADBEEF);
    fetch_op(8'h06, "t3_fetch");
    data_op(1'b1, 2'd3, 1'b0, 8'h10, 32'h0, "t3_rsvd", obs);

    // Both ports requesting continuously
    d_req = 1'b1; d_we = 1'b0; d_size = ACCESS_WORD; d_unsigned = 1'b0; d_addr = 8'h10;
    if_req = 1'b1; if_addr = 8'h10;
    losses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_if = (losses == LIM);
      check($sformatf("t4_d_gnt%0d", c), 32'(d_gnt), 32'(!exp_if));
      check($sformatf("t4_if_gnt%0d", c), 32'(if_gnt), 32'(exp_if));
      check($sformatf("t4_excl%0d", c), 32'(d_gnt && if_gnt), 32'd0);
      losses = exp_if ? 0 : losses + 1;
      prev_d = !exp_if;
      @(posedge clk);
      #1;
      check($sformatf("t4_d_valid%0d", c), 32'(d_rsp_valid), 32'(prev_d));
      check($sformatf("t4_if_valid%0d", c), 32'(if_rsp_valid), 32'(!prev_d));
      check($sformatf("t4_rdata%0d", c), prev_d ? d_rdata : if_rdata, 32'h7FADBEEF);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset arriving while a fetch is being granted
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    check("t5_gnt_pre", 32'(if_gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_gnt_rst", 32'(if_gnt), 32'd0);
    @(posedge clk);
    #1;
    check("t5_valid", 32'(if_rsp_valid), 32'd0);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    for (int w = 0; w < 64; w++) data_op(1'b0, 2'd2, 1'b0, 8'(4 * w), 32'h0, $sformatf("t5_zero%0d", w), obs);

    // Store followed immediately by load of the same word
    data_op(1'b1, 2'd2, 1'b0, 8'h20, 32'd5, "t6_st", obs);
    data_op(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, "t6_ld", obs);
    check("t6_const", obs, 32'd5);

    // Random mix over a small window so accesses collide
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0: data_op(1'b1, 2'($urandom_range(0, 3)), 1'b0, 8'($urandom_range(0, 31)), $urandom,
                   $sformatf("r%0d_st", n), obs);
        1: data_op(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                   32'h0, $sformatf("r%0d_ld", n), obs);
        default: fetch_op(8'($urandom_range(0, 31)), $sformatf("r%0d_if", n));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
